instruction_fetch_unit: RTL and testbench

Front-end fetch stage. Sits directly upstream of the instruction cache:
- generates sequential fetch addresses and drives the cache core interface;
- buffers returned instructions with their PCs in a small FIFO feeding decode;
- flushes and restarts on a redirect (branch, jump or trap).

---
 rtl/instruction_fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instruction_fetch_unit.sv | 96 +++++++++
 tb/tb_instruction_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package instruction_fetch_pkg;

    localparam int INST_BYTES = 4;
    localparam int ENTRY_BITS = 64;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - {pc, instruction} buffer between fetch and decode; flush beats push and pop
import instruction_fetch_pkg::*;

module fetch_fifo #(
    parameter int DEPTH     = 4,
    parameter int LOG_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [ENTRY_BITS-1:0] push_entry,
    output logic [ENTRY_BITS-1:0] head_entry,
    output logic [LOG_DEPTH:0]    count,
    output logic                  full,
    output logic                  empty
);

    localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH + 1)'(DEPTH);

    logic [ENTRY_BITS-1:0] mem [DEPTH];
    logic [LOG_DEPTH-1:0]  head;
    logic [LOG_DEPTH-1:0]  tail;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_entry = mem[head];

    // Storage needs no reset: an entry is only observed once count covers it.
    always_ff @(posedge clock) begin
        if (!reset && !flush && do_push) begin
            mem[tail] <= push_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - sequential fetch, cache request and decode buffer; IFU_PERF_COUNTERS_EN adds perf counters
import instruction_fetch_pkg::*;

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          LOG_FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] cache_address,
    output logic        cache_read,
    input  logic [31:0] cache_instruction,
    input  logic        cache_waitrequest,
    input  logic        cache_inst_valid,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        decode_valid,
    output logic [31:0] decode_instruction,
    output logic [31:0] decode_pc,
`ifdef IFU_PERF_COUNTERS_EN
    output logic [31:0] perf_fetch_count,
    output logic [31:0] perf_stall_count,
`endif
    input  logic        decode_ready
);

    localparam logic [LOG_FIFO_DEPTH:0] FULL_COUNT = (LOG_FIFO_DEPTH + 1)'(FIFO_DEPTH);

    logic [31:0]               fetch_pc;
    logic                      completion;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [LOG_FIFO_DEPTH:0]   fifo_count;
    fetch_entry_t              push_entry;
    fetch_entry_t              head_entry;

    assign cache_address = fetch_pc;
    assign cache_read    = ~reset & fetch_enable & ~redirect_valid & (fifo_count != FULL_COUNT);
    assign completion    = cache_read & ~cache_waitrequest & cache_inst_valid;

    assign push_entry = '{pc: fetch_pc, instruction: cache_instruction};
    assign fifo_push  = completion & ~fifo_full;
    assign fifo_pop   = decode_valid & decode_ready & ~redirect_valid;

    fetch_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .LOG_DEPTH (LOG_FIFO_DEPTH)
    ) u_fetch_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .flush      (redirect_valid),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign decode_valid       = ~fifo_empty;
    assign decode_instruction = decode_valid ? head_entry.instruction : 32'h0;
    assign decode_pc          = decode_valid ? head_entry.pc : 32'h0;

    // The address advances only on completion, so a waiting request keeps it stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        end else if (completion) begin
            fetch_pc <= fetch_pc + 32'(INST_BYTES);
        end
    end

`ifdef IFU_PERF_COUNTERS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_count <= '0;
            perf_stall_count <= '0;
        end else begin
            if (completion) begin
                perf_fetch_count <= perf_fetch_count + 32'd1;
            end
            if (cache_read && !completion) begin
                perf_stall_count <= perf_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit; honours IFU_PERF_COUNTERS_EN
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 4;

    logic        clock;
    logic        reset;
    logic [31:0] cache_address;
    logic        cache_read;
    logic [31:0] cache_instruction;
    logic        cache_waitrequest;
    logic        cache_inst_valid;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        decode_valid;
    logic [31:0] decode_instruction;
    logic [31:0] decode_pc;
    logic        decode_ready;
`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_stall_count;
`endif

    instruction_fetch_unit #(
        .RESET_PC       (RESET_PC),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .LOG_FIFO_DEPTH (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .cache_address      (cache_address),
        .cache_read         (cache_read),
        .cache_instruction  (cache_instruction),
        .cache_waitrequest  (cache_waitrequest),
        .cache_inst_valid   (cache_inst_valid),
        .fetch_enable       (fetch_enable),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .decode_valid       (decode_valid),
        .decode_instruction (decode_instruction),
        .decode_pc          (decode_pc),
`ifdef IFU_PERF_COUNTERS_EN
        .perf_fetch_count   (perf_fetch_count),
        .perf_stall_count   (perf_stall_count),
`endif
        .decode_ready       (decode_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_entry_t;

    exp_entry_t  exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_fetches;
    logic [31:0] model_stalls;
    int          checks;
    int          errors;
    bit          mon_en;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reads the decode side mid-cycle and retires scoreboard entries on pops.
    always @(negedge clock) begin
        #2;
        if (mon_en) begin
            logic [31:0] e_pc;
            logic [31:0] e_in;
            e_pc = (exp_q.size() != 0) ? exp_q[0].pc : 32'h0;
            e_in = (exp_q.size() != 0) ? exp_q[0].instr : 32'h0;
            check32("decode_valid", {31'h0, decode_valid}, {31'h0, exp_q.size() != 0});
            check32("decode_pc", decode_pc, e_pc);
            check32("decode_instruction", decode_instruction, e_in);
            if (decode_ready && !redirect_valid && !reset && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic rst, input logic fe, input logic wr, input logic iv,
                        input logic rv, input logic [31:0] rpc, input logic dr);
        logic exp_read;
        logic completes;
        @(negedge clock);
        reset             = rst;
        fetch_enable      = fe;
        cache_waitrequest = wr;
        cache_inst_valid  = iv;
        cache_instruction = $urandom;
        redirect_valid    = rv;
        redirect_pc       = rpc;
        decode_ready      = dr;
        #1;
        exp_read = !rst && fe && !rv && (exp_q.size() != FIFO_DEPTH);
        check32("cache_read", {31'h0, cache_read}, {31'h0, exp_read});
        check32("cache_address", cache_address, model_pc);
`ifdef IFU_PERF_COUNTERS_EN
        check32("perf_fetch_count", perf_fetch_count, model_fetches);
        check32("perf_stall_count", perf_stall_count, model_stalls);
`endif
        completes = exp_read && !wr && iv;
        #2;
        if (rst) begin
            exp_q.delete();
            model_pc      = RESET_PC;
            model_fetches = 32'h0;
            model_stalls  = 32'h0;
        end else begin
            if (completes) model_fetches = model_fetches + 32'd1;
            if (exp_read && !completes) model_stalls = model_stalls + 32'd1;
            if (rv) begin
                exp_q.delete();
                model_pc = {rpc[31:2], 2'b00};
            end else if (completes) begin
                exp_q.push_back('{pc: model_pc, instr: cache_instruction});
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        mon_en            = 1'b0;
        model_pc          = RESET_PC;
        model_fetches     = 32'h0;
        model_stalls      = 32'h0;
        reset             = 1'b1;
        fetch_enable      = 1'b0;
        cache_waitrequest = 1'b0;
        cache_inst_valid  = 1'b0;
        cache_instruction = 32'h0;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        decode_ready      = 1'b0;
        repeat (2) @(posedge clock);
        mon_en = 1'b1;

        // Reset state, then sustained hits with decode always ready.
        step(1, 0, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 0, 32'h0, 1);

        // Miss for five cycles at 0x40, then the hit.
        step(0, 1, 0, 1, 1, 32'h40, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, 32'h0, 1);
        step(0, 1, 0, 1, 0, 32'h0, 1);

        // Fill to full with decode stalled, one pop, then resume.
        step(0, 1, 0, 1, 1, 32'h0, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 0, 32'h0, 0);
        step(0, 1, 0, 1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 32'h0, 0);

        // Three buffered entries plus an arriving hit, then redirect to a misaligned PC.
        step(0, 0, 0, 1, 0, 32'h0, 1);
        step(0, 1, 0, 1, 1, 32'h1002, 1);
        step(0, 1, 0, 1, 0, 32'h0, 1);
        step(0, 1, 0, 1, 0, 32'h0, 1);

        // Address wraps past the top of memory.
        step(0, 1, 0, 1, 1, 32'hFFFF_FFFC, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 32'h0, 1);

        // Reset during a pending miss with entries buffered.
        for (int i = 0; i < 2; i++) step(0, 1, 0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0, 32'h0, 0);
        step(1, 1, 1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 0, 0, 32'h0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0),
                 $urandom,
                 ($urandom_range(0, 1) == 1));
        end

        @(negedge clock);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
